// File: rtl/timer_countdown.sv
// ---------------------------------------------------------------------------
// timer_countdown
//   MM:SS countdown timer. The preset is edited with one-cycle switch pulses
//   while idle in SET. The timer counts down once per second while the
//   upstream run level TIMER_ONOFF is 1, and pauses while it is 0. On reaching
//   00:00 it raises ALARM for ALARM_SEC ticks. The time is held in BCD
//   throughout, so the display mux can use the registers directly.
//
// Parameters
//   TICK_DIV   CLK cycles per one-second tick (>=2)
//   ALARM_SEC  ALARM duration in ticks (>=1)
//   MAX_MIN    highest settable minute value (<=99)
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   TIMER_ONOFF  in   run request level (1=run, 0=stop)
//   SW_MIN       in   one-cycle pulse, minute +1 (SET only)
//   SW_SEC       in   one-cycle pulse, second +1 (SET only)
//   SW_CLR       in   one-cycle pulse, clear to 00:00 / abort
//   MIN_BCD      out  minutes {tens,units} BCD
//   SEC_BCD      out  seconds {tens,units} BCD
//   RUNNING      out  1 while in RUN
//   ALARM        out  1 while in ALARM
//
// The FSM state is kept in the enum signal 'state', so checkers can observe
// it through the hierarchy. All outputs are registered, and each response
// appears on the CLK edge after the input that causes it.
// ---------------------------------------------------------------------------
module timer_countdown #(
  parameter int TICK_DIV  = 1000,
  parameter int ALARM_SEC = 5,
  parameter int MAX_MIN   = 59
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TIMER_ONOFF,
  input  logic       SW_MIN,
  input  logic       SW_SEC,
  input  logic       SW_CLR,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic       RUNNING,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST  = AW'(ALARM_SEC - 1);
  localparam logic [7:0]    MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0]    MAX_SEC_BCD = 8'h59;

  state_t          state, next_state;
  logic [PW-1:0]   presc, presc_next;
  logic [AW-1:0]   alarm_cnt, alarm_cnt_next;
  logic [7:0]      min_next, sec_next;
  logic [7:0]      min_dec, sec_dec;
  logic            running_next, alarm_next;
  logic            tick, time_zero, dec_zero, state_change;

  // BCD +1, wrapping to 00 once the value has reached 'top'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD -1. The caller ensures that v is not zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // The prescaler only advances in RUN and ALARM, so a tick exists only there.
  assign tick = ((state == ST_RUN) || (state == ST_ALARM)) && (presc == PRESC_LAST);

  assign time_zero = (MIN_BCD == 8'h00) && (SEC_BCD == 8'h00);

  // Value after one tick. Seconds borrow from minutes at 00.
  always_comb begin
    if (SEC_BCD != 8'h00) begin
      sec_dec = bcd_dec(SEC_BCD);
      min_dec = MIN_BCD;
    end else begin
      sec_dec = MAX_SEC_BCD;
      min_dec = bcd_dec(MIN_BCD);
    end
  end

  assign dec_zero = (min_dec == 8'h00) && (sec_dec == 8'h00);

  // -------------------------------------------------------------------------
  // State register and registered datapath/outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_SET;
      presc     <= '0;
      alarm_cnt <= '0;
      MIN_BCD   <= 8'h00;
      SEC_BCD   <= 8'h00;
      RUNNING   <= 1'b0;
      ALARM     <= 1'b0;
    end else begin
      state     <= next_state;
      presc     <= presc_next;
      alarm_cnt <= alarm_cnt_next;
      MIN_BCD   <= min_next;
      SEC_BCD   <= sec_next;
      RUNNING   <= running_next;
      ALARM     <= alarm_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      ST_SET: begin
        // A clear in the same cycle leaves 00:00, so it also blocks the start.
        if (!SW_CLR && TIMER_ONOFF && !time_zero)
          next_state = ST_RUN;
      end
      ST_RUN: begin
        // Priority: clear, then stop, then the tick.
        if (SW_CLR)
          next_state = ST_SET;
        else if (!TIMER_ONOFF)
          next_state = ST_PAUSE;
        else if (tick && dec_zero)
          next_state = ST_ALARM;
      end
      ST_PAUSE: begin
        if (SW_CLR)
          next_state = ST_SET;
        else if (TIMER_ONOFF)
          next_state = ST_RUN;
      end
      ST_ALARM: begin
        if (SW_CLR || !TIMER_ONOFF)
          next_state = ST_SET;
        else if (tick && (alarm_cnt == ALARM_LAST))
          next_state = ST_SET;
      end
      default: next_state = ST_SET;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  assign state_change = (next_state != state);

  always_comb begin
    min_next = MIN_BCD;
    sec_next = SEC_BCD;
    unique case (state)
      ST_SET: begin
        if (SW_CLR) begin
          min_next = 8'h00;
          sec_next = 8'h00;
        end else begin
          // Minute and second edits are independent, so both can apply at once.
          if (SW_MIN)
            min_next = bcd_inc(MIN_BCD, MAX_MIN_BCD);
          if (SW_SEC)
            sec_next = bcd_inc(SEC_BCD, MAX_SEC_BCD);
        end
      end
      ST_RUN: begin
        if (SW_CLR) begin
          min_next = 8'h00;
          sec_next = 8'h00;
        end else if (TIMER_ONOFF && tick) begin
          min_next = min_dec;
          sec_next = sec_dec;
        end
      end
      ST_PAUSE: begin
        if (SW_CLR) begin
          min_next = 8'h00;
          sec_next = 8'h00;
        end
      end
      ST_ALARM: begin
        min_next = 8'h00;
        sec_next = 8'h00;
      end
      default: begin
        min_next = 8'h00;
        sec_next = 8'h00;
      end
    endcase

    // The prescaler restarts on every state entry. The first tick in a new
    // state therefore comes TICK_DIV cycles after that entry.
    if (state_change || !((state == ST_RUN) || (state == ST_ALARM)))
      presc_next = '0;
    else if (tick)
      presc_next = '0;
    else
      presc_next = presc + PW'(1);

    if (state_change || (state != ST_ALARM))
      alarm_cnt_next = '0;
    else if (tick)
      alarm_cnt_next = alarm_cnt + AW'(1);
    else
      alarm_cnt_next = alarm_cnt;

    running_next = (next_state == ST_RUN);
    alarm_next   = (next_state == ST_ALARM);
  end

endmodule

// File: tb/tb_timer_countdown.sv
// ---------------------------------------------------------------------------
// tb_timer_countdown
//   Directed testbench for timer_countdown with TICK_DIV=4, ALARM_SEC=2 and
//   MAX_MIN=59. The driver applies inputs on the falling edge. For each
//   cycle it wants checked, it pushes the expected {MIN,SEC,RUNNING,ALARM}
//   that should follow the next rising edge, tagged with that edge's number.
//   The monitor samples 2 ns after every rising edge, pops the entries due at
//   that edge and compares them.
// ---------------------------------------------------------------------------
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       reset;
  logic       onoff;
  logic       sw_min;
  logic       sw_sec;
  logic       sw_clr;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       alarm;

  // Expected {min, sec, running, alarm}, its due edge and its label.
  logic [17:0] exp_q[$];
  int          tag_q[$];
  string       name_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  timer_countdown #(
    .TICK_DIV  (4),
    .ALARM_SEC (2),
    .MAX_MIN   (59)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .TIMER_ONOFF (onoff),
    .SW_MIN      (sw_min),
    .SW_SEC      (sw_sec),
    .SW_CLR      (sw_clr),
    .MIN_BCD     (min_bcd),
    .SEC_BCD     (sec_bcd),
    .RUNNING     (running),
    .ALARM       (alarm)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [17:0] want;
    logic [17:0] got;
    string       nm;
    cyc = cyc + 1;
    #2;
    while ((tag_q.size() > 0) && (tag_q[0] <= cyc)) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      void'(tag_q.pop_front());
      got  = {min_bcd, sec_bcd, running, alarm};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s edge %0d: got min=%h sec=%h run=%b alarm=%b, want min=%h sec=%h run=%b alarm=%b",
                 nm, cyc, got[17:10], got[9:2], got[1], got[0],
                 want[17:10], want[9:2], want[1], want[0]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic expect_out(input string name, input int m, input int s,
                            input logic r, input logic a);
    exp_q.push_back({to_bcd(m), to_bcd(s), r, a});
    tag_q.push_back(cyc + 1);
    name_q.push_back(name);
  endtask

  // Drive one cycle of inputs, then queue the state expected after the next edge.
  task automatic step(input string name, input logic on, input logic mn,
                      input logic sc, input logic cl, input int m, input int s,
                      input logic r, input logic a);
    @(negedge clk);
    onoff  = on;
    sw_min = mn;
    sw_sec = sc;
    sw_clr = cl;
    expect_out(name, m, s, r, a);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int rem;
    reset  = 1'b1;
    onoff  = 1'b0;
    sw_min = 1'b0;
    sw_sec = 1'b0;
    sw_clr = 1'b0;

    // 1: reset values, then start request at 00:00 stays in SET
    step("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step("start_at_zero", 1, 0, 0, 0, 0, 0, 0, 0);
    step("start_at_zero", 1, 0, 0, 0, 0, 0, 0, 0);

    // 2: editing in SET
    step("sec_inc", 0, 0, 1, 0, 0, 1, 0, 0);
    step("sec_inc", 0, 0, 1, 0, 0, 2, 0, 0);
    step("sec_inc", 0, 0, 1, 0, 0, 3, 0, 0);
    step("min_inc", 0, 1, 0, 0, 1, 3, 0, 0);
    step("min_inc", 0, 1, 0, 0, 2, 3, 0, 0);
    step("clr", 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 60; i++)
      step("sec_wrap", 0, 0, 1, 0, 0, i % 60, 0, 0);
    for (int i = 1; i <= 60; i++)
      step("min_wrap", 0, 1, 0, 0, i % 60, 0, 0, 0);
    step("min_sec_both", 0, 1, 1, 0, 1, 1, 0, 0);
    step("clr", 0, 0, 0, 1, 0, 0, 0, 0);

    // 3: 01:00 counts all the way down, then the full alarm
    step("set_0100", 0, 1, 0, 0, 1, 0, 0, 0);
    step("run_enter", 1, 0, 0, 0, 1, 0, 1, 0);
    for (int t = 1; t <= 60; t++) begin
      rem = 61 - t;
      for (int k = 0; k < 3; k++)
        step("run_hold", 1, 0, 0, 0, rem / 60, rem % 60, 1, 0);
      rem = 60 - t;
      if (rem > 0)
        step("run_tick", 1, 0, 0, 0, rem / 60, rem % 60, 1, 0);
      else
        step("run_to_alarm", 1, 0, 0, 0, 0, 0, 0, 1);
    end
    for (int k = 1; k <= 7; k++)
      step("alarm_hold", 1, 0, 0, 0, 0, 0, 0, 1);
    step("alarm_end", 1, 0, 0, 0, 0, 0, 0, 0);
    step("set_stay_on", 1, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // 4: pause on a tick cycle, switches ignored, resume
    step("sec_inc", 0, 0, 1, 0, 0, 1, 0, 0);
    step("sec_inc", 0, 0, 1, 0, 0, 2, 0, 0);
    step("run2_enter", 1, 0, 0, 0, 0, 2, 1, 0);
    step("run_ignore_sw", 1, 1, 1, 0, 0, 2, 1, 0);
    step("run2_hold", 1, 0, 0, 0, 0, 2, 1, 0);
    step("run2_hold", 1, 0, 0, 0, 0, 2, 1, 0);
    step("pause_on_tick", 0, 0, 0, 0, 0, 2, 0, 0);
    step("pause_hold", 0, 0, 0, 0, 0, 2, 0, 0);
    step("pause_ignore_sw", 0, 1, 1, 0, 0, 2, 0, 0);
    step("resume", 1, 0, 0, 0, 0, 2, 1, 0);
    for (int k = 0; k < 3; k++)
      step("resume_hold", 1, 0, 0, 0, 0, 2, 1, 0);
    step("resume_tick", 1, 0, 0, 0, 0, 1, 1, 0);

    // 5: 00:01 -> alarm, then abort it with SW_CLR
    for (int k = 0; k < 3; k++)
      step("run_hold_01", 1, 0, 0, 0, 0, 1, 1, 0);
    step("alarm2_enter", 1, 0, 0, 0, 0, 0, 0, 1);
    step("alarm2_hold", 1, 0, 0, 0, 0, 0, 0, 1);
    step("alarm2_hold", 1, 0, 0, 0, 0, 0, 0, 1);
    step("alarm_clr", 1, 0, 0, 1, 0, 0, 0, 0);
    step("set_stay_on2", 1, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // 6: reset mid-run at 05:30
    for (int i = 1; i <= 5; i++)
      step("set_min5", 0, 1, 0, 0, i, 0, 0, 0);
    for (int i = 1; i <= 30; i++)
      step("set_sec30", 0, 0, 1, 0, 5, i, 0, 0);
    step("run3_enter", 1, 0, 0, 0, 5, 30, 1, 0);
    step("run3_hold", 1, 0, 0, 0, 5, 30, 1, 0);
    step("run3_hold", 1, 0, 0, 0, 5, 30, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    onoff = 1'b0;
    expect_out("reset_mid_run", 0, 0, 0, 0);
    step("reset_mid_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // No prescaler phase survives reset: first tick is 4 edges after entry.
    step("sec_inc", 0, 0, 1, 0, 0, 1, 0, 0);
    step("run4_enter", 1, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++)
      step("run4_hold", 1, 0, 0, 0, 0, 1, 1, 0);
    step("run4_tick_alarm", 1, 0, 0, 0, 0, 0, 0, 1);
    step("alarm_onoff_off", 0, 0, 0, 0, 0, 0, 0, 0);
    step("sec_inc", 0, 0, 1, 0, 0, 1, 0, 0);
    step("clr_wins_min", 0, 1, 0, 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
